// File: rtl/alu_seq_core.sv
// WIDTH-bit sequenced ALU with a Start/Busy/Done handshake; MUL iterates one bit per cycle.
// Define ALU_SEQ_DIV_EN to build the restoring divider (otherwise opcode 0x11 is illegal).
module alu_seq_core #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [7:0]       ALU_Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       StatusIn,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic [7:0]       SetSR,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal
);

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_ADC = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_SBB = 8'h04;
    localparam logic [7:0] OP_AND = 8'h05;
    localparam logic [7:0] OP_OR  = 8'h06;
    localparam logic [7:0] OP_XOR = 8'h07;
    localparam logic [7:0] OP_NOT = 8'h08;
    localparam logic [7:0] OP_SHL = 8'h09;
    localparam logic [7:0] OP_SHR = 8'h0A;
    localparam logic [7:0] OP_SAR = 8'h0B;
    localparam logic [7:0] OP_CMP = 8'h0C;
    localparam logic [7:0] OP_MUL = 8'h10;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [7:0] OP_DIV = 8'h11;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} stateT;
    stateT state, stateNext;

    logic [WIDTH:0]   addSum, subDiff, shlVal, shrVal, sarVal;
    logic             addCin, subBin, addOvf, subOvf;
    logic [SHW-1:0]   shAmt;
    logic             startIter;
    logic [WIDTH-1:0] execResult, execHi, znVal;
    logic [7:0]       execSR;
    logic             execIllegal, execKeep, cOut, vOut, dzOut;

    logic [WIDTH-1:0] accHi, accLo, opnd, iterHi, iterLo;
    logic [SHW-1:0]   cnt;
    logic             lastIter, mulCarry;
    logic [7:0]       statusLat, iterSR;
    logic [WIDTH:0]   mulSum;
`ifdef ALU_SEQ_DIV_EN
    logic             isDiv;
    logic [WIDTH:0]   divShift, divDiff;
`endif

    // Single-cycle datapath, evaluated on the live inputs at the Start edge
    assign addCin  = (ALU_Sel == OP_ADC) & StatusIn[0];
    assign subBin  = (ALU_Sel == OP_SBB) & StatusIn[0];
    assign addSum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, addCin};
    assign subDiff = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, subBin};
    assign addOvf  = (A[WIDTH-1] == B[WIDTH-1]) && (addSum[WIDTH-1] != A[WIDTH-1]);
    assign subOvf  = (A[WIDTH-1] != B[WIDTH-1]) && (subDiff[WIDTH-1] != A[WIDTH-1]);

    // Extra bit beside the operand catches the last bit shifted out (0 for amount 0)
    assign shAmt  = B[SHW-1:0];
    assign shlVal = {1'b0, A} << shAmt;
    assign shrVal = {A, 1'b0} >> shAmt;
    assign sarVal = $unsigned($signed({A, 1'b0}) >>> shAmt);

    always_comb begin
        startIter = (ALU_Sel == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
        if ((ALU_Sel == OP_DIV) && (B != '0)) startIter = 1'b1;
`endif
    end

    always_comb begin
        execResult  = '0;
        execHi      = '0;
        execIllegal = 1'b0;
        execKeep    = 1'b0;
        cOut        = StatusIn[0];
        vOut        = StatusIn[3];
        dzOut       = StatusIn[4];
        case (ALU_Sel)
            OP_NOP: begin
                execResult = A;
                execKeep   = 1'b1;
            end
            OP_ADD, OP_ADC: begin
                execResult = addSum[WIDTH-1:0];
                cOut       = addSum[WIDTH];
                vOut       = addOvf;
            end
            OP_SUB, OP_SBB: begin
                execResult = subDiff[WIDTH-1:0];
                cOut       = subDiff[WIDTH];
                vOut       = subOvf;
            end
            OP_CMP: begin
                execResult = A;
                cOut       = subDiff[WIDTH];
                vOut       = subOvf;
            end
            OP_AND: begin execResult = A & B; cOut = 1'b0; vOut = 1'b0; end
            OP_OR:  begin execResult = A | B; cOut = 1'b0; vOut = 1'b0; end
            OP_XOR: begin execResult = A ^ B; cOut = 1'b0; vOut = 1'b0; end
            OP_NOT: begin execResult = ~A;    cOut = 1'b0; vOut = 1'b0; end
            OP_SHL: begin
                execResult = shlVal[WIDTH-1:0];
                cOut       = shlVal[WIDTH];
                vOut       = 1'b0;
            end
            OP_SHR: begin
                execResult = shrVal[WIDTH:1];
                cOut       = shrVal[0];
                vOut       = 1'b0;
            end
            OP_SAR: begin
                execResult = sarVal[WIDTH:1];
                cOut       = sarVal[0];
                vOut       = 1'b0;
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                execResult = '1;
                execHi     = A;
                cOut       = 1'b0;
                vOut       = 1'b0;
                dzOut      = 1'b1;
            end
`endif
            default: begin
                execIllegal = 1'b1;
                execKeep    = 1'b1;
            end
        endcase
        znVal  = (ALU_Sel == OP_CMP) ? subDiff[WIDTH-1:0] : execResult;
        execSR = execKeep ? StatusIn
                          : {StatusIn[7:5], dzOut, vOut, znVal[WIDTH-1], (znVal == '0), cOut};
    end

    // One iteration step: shift-add multiply, or restoring divide when built in
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
        iterHi   = mulSum[WIDTH:1];
        iterLo   = {mulSum[0], accLo[WIDTH-1:1]};
        mulCarry = (iterHi != '0);
        iterSR   = {statusLat[7:5], statusLat[4], mulCarry, iterLo[WIDTH-1],
                    ((iterHi == '0) && (iterLo == '0)), mulCarry};
`ifdef ALU_SEQ_DIV_EN
        divShift = {accHi, accLo[WIDTH-1]};
        divDiff  = divShift - {1'b0, opnd};
        if (isDiv) begin
            if (!divDiff[WIDTH]) begin
                iterHi = divDiff[WIDTH-1:0];
                iterLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                iterHi = divShift[WIDTH-1:0];
                iterLo = {accLo[WIDTH-2:0], 1'b0};
            end
            iterSR = {statusLat[7:5], 1'b0, 1'b0, iterLo[WIDTH-1], (iterLo == '0), 1'b0};
        end
`endif
    end

    assign lastIter = (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: if (Start) stateNext = startIter ? ITER : EXEC;
            EXEC: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                stateNext = IDLE;
            end
            ITER: begin
                Busy = 1'b1;
                if (lastIter) stateNext = FIN;
            end
            FIN: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Single-cycle results are registered at the Start edge so they are valid in the EXEC (Done) cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Result    <= '0;
            ResultHi  <= '0;
            SetSR     <= '0;
            Illegal   <= 1'b0;
            accHi     <= '0;
            accLo     <= '0;
            opnd      <= '0;
            cnt       <= '0;
            statusLat <= '0;
`ifdef ALU_SEQ_DIV_EN
            isDiv     <= 1'b0;
`endif
        end else if ((state == IDLE) && Start) begin
            statusLat <= StatusIn;
            cnt       <= '0;
            if (startIter) begin
                accHi <= '0;
`ifdef ALU_SEQ_DIV_EN
                isDiv <= (ALU_Sel == OP_DIV);
                accLo <= (ALU_Sel == OP_DIV) ? A : B;
                opnd  <= (ALU_Sel == OP_DIV) ? B : A;
`else
                accLo <= B;
                opnd  <= A;
`endif
            end else begin
                Result   <= execResult;
                ResultHi <= execHi;
                SetSR    <= execSR;
                Illegal  <= execIllegal;
            end
        end else if (state == ITER) begin
            accHi <= iterHi;
            accLo <= iterLo;
            cnt   <= cnt + 1'b1;
            if (lastIter) begin
                Result   <= iterLo;
                ResultHi <= iterHi;
                SetSR    <= iterSR;
                Illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised successor to the soft-CPU ALU: a WIDTH-bit execution unit with a Start/Busy/Done handshake to the decoder/sequencer.
- Single-cycle ops cover logic, arithmetic and shifts.
- Multi-cycle iterative ops cover multiply and (optionally) divide.
- Produces status-register updates (C/Z/N/V/DZ) for the CPU status register.

Parameters:
- WIDTH, 32, datapath width in bits; power of 2, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  operation request; sampled only in IDLE
- ALU_Sel  input  8  opcode
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- StatusIn  input  8  current status register value
- Result  output  WIDTH  primary result / low product / quotient
- ResultHi  output  WIDTH  high product / remainder; 0 for other ops
- SetSR  output  8  new status register value
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse: Result/ResultHi/SetSR valid
- Illegal  output  1  high with Done when opcode is unsupported

Behaviour:
- Reset: state IDLE; Result=0, ResultHi=0, SetSR=0, Busy=0, Done=0, Illegal=0. Reset asserted mid-operation aborts it with no Done.
- Start latch: in IDLE, Start=1 latches A, B, ALU_Sel and StatusIn. Later input changes have no effect on the operation.
- States: IDLE -> EXEC (single-cycle op, illegal opcode, DIV by zero) or ITER (MUL/DIV). EXEC -> IDLE, Done=1. ITER runs exactly WIDTH cycles -> FIN -> IDLE, Done=1.
- Latency from the Start edge:
  - Single-cycle ops: Done at the next edge (1 cycle).
  - Iterative ops: Done after WIDTH+1 cycles.
- Busy: 1 from the cycle after Start until and including the Done cycle. Start while Busy is ignored.
- Done is high for exactly one cycle. Outputs hold their values until the next Done.
- Opcodes:
  - 0x00 NOP: Result=A, flags unchanged.
  - 0x01 ADD, 0x02 ADC (+StatusIn[0]), 0x03 SUB, 0x04 SBB (-StatusIn[0]).
  - 0x05 AND, 0x06 OR, 0x07 XOR, 0x08 NOT A.
  - 0x09 SHL, 0x0A SHR, 0x0B SAR; shift amount is B[SHW-1:0].
  - 0x0C CMP: SUB flags only; Result=A.
  - 0x10 MUL: unsigned.
  - 0x11 DIV: unsigned.
- SetSR bit map:
  - [0] C; [1] Z; [2] N = Result[WIDTH-1]; [3] V; [4] DZ.
  - [7:5] passed from the latched StatusIn.
  - Flags an op does not define keep their StatusIn value.
- Arithmetic flags: computed at WIDTH+1 bits.
  - ADD/ADC: C = carry-out, V = signed overflow.
  - SUB/SBB/CMP: C = borrow (1 when A < B + cin unsigned), V = signed overflow.
  - Z = (Result==0).
  - Logic ops: C=0, V=0.
- Shifts:
  - C = last bit shifted out; amount 0 gives C=0 and Result=A. V=0.
  - SAR replicates the sign bit.
- MUL: shift-add, one bit per cycle. {ResultHi,Result} = A*B (2*WIDTH bits). Z = full product == 0. C = V = (ResultHi != 0). N = Result MSB.
- DIV: restoring, one bit per cycle. Result = A/B, ResultHi = A%B, DZ=0.
  - B==0 takes the EXEC path (1 cycle): Result = all ones, ResultHi = A, DZ=1, C=V=0.
- Illegal opcode: EXEC path. Result=0, ResultHi=0, SetSR = latched StatusIn, Illegal=1 with Done.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIV (0x11) implemented as specified above.
- Undefined: divider logic is absent; 0x11 is treated as an illegal opcode (1-cycle Done, Illegal=1).

Test Plan:
- Reset/handshake: Reset=1 for 2 cycles, then Start ADD A=3, B=4 -> Done exactly 1 cycle later, Result=7, SetSR[3:0]=0000, Busy high only in the Done cycle.
- Overflow/borrow: ADD 0x7FFFFFFF+1 -> Result=0x80000000, N=1, V=1, C=0. SUB 0-1 -> Result=0xFFFFFFFF, C=1, N=1.
- Shifts: SAR 0x80000001 by 1 -> Result=0xC0000000, C=1. SHL by 0 -> Result=A, C=0.
- MUL timing: MUL 0xFFFFFFFF*2 -> Done 33 cycles after Start, ResultHi=1, Result=0xFFFFFFFE, C=1. Start pulses during Busy ignored (a single Done).
- DIV (macro on): 100/7 -> Result=14, ResultHi=2 after 33 cycles. 5/0 -> 1-cycle Done, Result=0xFFFFFFFF, ResultHi=5, SetSR[4]=1. Macro off: 0x11 -> Illegal=1.
- Abort/illegal: Reset at cycle 10 of a MUL -> no Done, outputs 0, next ADD works. Opcode 0xFF with StatusIn=0xA5 -> Illegal=1, SetSR=0xA5.
